// File: rtl/is_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// is_pkg -- shared FSM encoding and LOAD-phase length for is_feed_ctrl | rev 1.0
// -----------------------------------------------------------------------------
package is_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    LOAD_WAIT = 3'd2,
    LOAD      = 3'd3,
    STREAM    = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  // Each PE takes two cycles to pass its load enable on, plus one cycle to settle.
  function automatic int load_len(input int cols);
    return 2 * cols + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/is_skew_line.sv
`default_nettype none
// -----------------------------------------------------------------------------
// is_skew_line -- fixed-depth register delay line, one per PE row | rev 1.0
// -----------------------------------------------------------------------------
module is_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/is_feed_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// is_feed_ctrl -- preloads PE activations, then streams row-skewed weights | rev 1.0
// -----------------------------------------------------------------------------
module is_feed_ctrl
  import is_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int WIDTH_K = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH_K-1:0]      k_len,
  input  logic [ROWS*WIDTH_A-1:0] act_vec,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [ROWS*WIDTH_B-1:0] wei_vec,
  input  logic                    wei_valid,
  output logic                    wei_ready,
  output logic [ROWS*WIDTH_A-1:0] act_o,
  output logic [ROWS-1:0]         cell_sc_en_o,
  output logic                    reg_clear_o,
  output logic [ROWS*WIDTH_B-1:0] wei_o,
  output logic [ROWS-1:0]         pipeline_en_o,
  output logic [ROWS-1:0]         cell_en_o,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int LOAD_LEN = load_len(COLS);
  localparam int CNT_MAX  = (LOAD_LEN > ROWS) ? LOAD_LEN : ROWS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SK_W     = WIDTH_B + 2;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_K-1:0] remaining;
  logic               act_fire, wei_fire, last_fire;
  logic [ROWS-1:0]    row_last, tail;

  assign act_fire = act_ready & act_valid;
  assign wei_fire = wei_ready & wei_valid;

  always_comb begin
    state_nxt    = state;
    act_ready    = 1'b0;
    wei_ready    = 1'b0;
    reg_clear_o  = 1'b0;
    cell_sc_en_o = '0;
    busy         = 1'b1;
    done         = 1'b0;
    last_fire    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && (k_len != '0)) state_nxt = CLEAR;
      end
      CLEAR: begin
        reg_clear_o = 1'b1;
        state_nxt   = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        act_ready = 1'b1;
        if (act_valid) state_nxt = LOAD;
      end
      LOAD: begin
        cell_sc_en_o = '1;
        if (cnt == CNT_W'(LOAD_LEN - 1)) state_nxt = STREAM;
      end
      STREAM: begin
        wei_ready = 1'b1;
        if (wei_valid && (remaining == WIDTH_K'(1))) begin
          last_fire = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(ROWS - 1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      remaining <= '0;
      err       <= 1'b0;
      act_o     <= '0;
      tail      <= '0;
      cell_en_o <= '0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      err <= (state == IDLE) && start && (k_len == '0);
      if ((state == IDLE) && start && (k_len != '0)) remaining <= k_len;
      else if (wei_fire)                             remaining <= remaining - WIDTH_K'(1);
      if (act_fire) act_o <= act_vec;
      // A row stays enabled one cycle past the cycle its final weight is presented.
      tail <= row_last;
      if ((state == LOAD_WAIT) && (state_nxt == LOAD)) cell_en_o <= '1;
      else                                             cell_en_o <= cell_en_o & ~tail;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [SK_W-1:0] sk_in, sk_out;

    // Cycles without an accepted vector travel down the line as zero bubbles.
    assign sk_in = wei_fire ? {last_fire, 1'b1, wei_vec[r*WIDTH_B +: WIDTH_B]} : '0;

    is_skew_line #(
      .DEPTH (r + 1),
      .WIDTH (SK_W)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sk_in),
      .dout  (sk_out)
    );

    assign wei_o[r*WIDTH_B +: WIDTH_B] = sk_out[WIDTH_B-1:0];
    assign pipeline_en_o[r]            = sk_out[WIDTH_B];
    assign row_last[r]                 = sk_out[WIDTH_B+1];
  end

endmodule
`default_nettype wire
